multi_dataflow_streamer_gen: RTL

//  Parametrised, self-contained streamer between HWPE engine and TCDM: NB_IN load channels and NB_OUT store channels.

---
 rtl/multi_dataflow_streamer_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_dataflow_streamer_gen.sv
// TCDM streamer: NB_IN load and NB_OUT store channels, each with a linear address generator and FIFO.
// Define MULTI_DATAFLOW_STREAMER_GEN_PERF_EN to build the per-port stall counters.
module multi_dataflow_streamer_gen #(
  parameter  int NB_IN  = 3,
  parameter  int NB_OUT = 1,
  parameter  int DW     = 32,
  parameter  int FD     = 4,
  localparam int MP     = NB_IN + NB_OUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic [MP*32-1:0]   cfg_base_i,
  input  logic [MP*32-1:0]   cfg_stride_i,
  input  logic [MP*16-1:0]   cfg_len_i,
  output logic [MP-1:0]      tcdm_req_o,
  input  logic [MP-1:0]      tcdm_gnt_i,
  output logic [MP*32-1:0]   tcdm_add_o,
  output logic [MP-1:0]      tcdm_wen_o,
  output logic [MP*DW/8-1:0] tcdm_be_o,
  output logic [MP*DW-1:0]   tcdm_data_o,
  input  logic [MP*DW-1:0]   tcdm_r_data_i,
  input  logic [MP-1:0]      tcdm_r_valid_i,
  output logic [NB_IN-1:0]   src_valid_o,
  input  logic [NB_IN-1:0]   src_ready_i,
  output logic [NB_IN*DW-1:0] src_data_o,
  input  logic [NB_OUT-1:0]  snk_valid_i,
  output logic [NB_OUT-1:0]  snk_ready_o,
  input  logic [NB_OUT*DW-1:0] snk_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [MP*16-1:0]   stall_cnt_o
);
  localparam int PW = $clog2(FD);
  localparam logic [PW:0]   CNT_FULL   = (PW+1)'(FD);
  localparam logic [PW+1:0] CREDIT_MAX = (PW+2)'(FD);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e state_q, state_d;
  logic run, start_acc;
  logic [MP-1:0] ch_done;
  logic [MP*32-1:0] stride_q, stride_d;
  logic [MP*16-1:0] len_q, len_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (&ch_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_DONE);
  end

  assign run       = (state_q == ST_RUN);
  assign start_acc = (state_q == ST_IDLE) & start_i & ~clear_i;
  assign tcdm_be_o = '1;

  // Shadow copy of the job description; cfg_* may change freely once the job runs.
  always_comb begin
    stride_d = stride_q;
    len_d    = len_q;
    if (start_acc) begin
      stride_d = cfg_stride_i;
      len_d    = cfg_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stride_q <= '0;
      len_q    <= '0;
    end else begin
      stride_q <= stride_d;
      len_q    <= len_d;
    end
  end

  for (genvar i = 0; i < MP; i++) begin : g_ch
    localparam bit IS_LD = (i < NB_IN);
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   iss_q, iss_d, xfer_q, xfer_d, len;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          pend_q, pend_d, hold_q, hold_d;
    logic [DW-1:0] mem_q [FD];
    logic [DW-1:0] push_data;
    logic          req, grant, push, pop, xfer, empty, full;

    assign len   = len_q[i*16 +: 16];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign grant = req & tcdm_gnt_i[i];
    assign tcdm_req_o[i]         = req;
    assign tcdm_add_o[i*32 +: 32] = addr_q;

    if (IS_LD) begin : g_ld
      logic [PW+1:0] credit;
      // FIFO slots plus the read in flight bound the requests, so responses never overflow.
      assign credit = {1'b0, cnt_q} + {{(PW+1){1'b0}}, pend_q};
      assign req    = run & (hold_q | (enable_i & (iss_q < len) & (credit < CREDIT_MAX)));
      assign push   = pend_q & tcdm_r_valid_i[i];
      assign push_data = tcdm_r_data_i[i*DW +: DW];
      assign pop    = ~empty & src_ready_i[i];
      assign xfer   = pop;
      assign ch_done[i] = (xfer_q == len);
      assign src_valid_o[i]        = ~empty;
      assign src_data_o[i*DW +: DW] = empty ? '0 : mem_q[rp_q];
      assign tcdm_wen_o[i]          = 1'b1;
      assign tcdm_data_o[i*DW +: DW] = '0;
    end else begin : g_st
      localparam int S = i - NB_IN;
      logic rdy, unused_rd;
      assign rdy    = run & ~full & (xfer_q < len);
      assign push   = rdy & snk_valid_i[S];
      assign push_data = snk_data_i[S*DW +: DW];
      assign req    = run & (hold_q | (enable_i & ~empty & (iss_q < len)));
      assign pop    = grant;
      assign xfer   = push;
      assign ch_done[i] = (iss_q == len);
      assign snk_ready_o[S]          = rdy;
      assign tcdm_wen_o[i]           = ~req;
      assign tcdm_data_o[i*DW +: DW] = req ? mem_q[rp_q] : '0;
      assign unused_rd = ^{tcdm_r_data_i[i*DW +: DW], tcdm_r_valid_i[i], pend_q};
    end

    always_comb begin
      addr_d = addr_q;
      iss_d  = iss_q;
      xfer_d = xfer_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      pend_d = IS_LD & grant;
      hold_d = req & ~tcdm_gnt_i[i];
      if (grant) begin
        addr_d = addr_q + stride_q[i*32 +: 32];
        iss_d  = iss_q + 16'd1;
      end
      if (xfer) xfer_d = xfer_q + 16'd1;
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (clear_i | start_acc) begin
        addr_d = start_acc ? cfg_base_i[i*32 +: 32] : '0;
        iss_d  = '0;
        xfer_d = '0;
        wp_d   = '0;
        rp_d   = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
        hold_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        addr_q <= '0;
        iss_q  <= '0;
        xfer_q <= '0;
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        pend_q <= 1'b0;
        hold_q <= 1'b0;
      end else begin
        addr_q <= addr_d;
        iss_q  <= iss_d;
        xfer_q <= xfer_d;
        wp_q   <= wp_d;
        rp_q   <= rp_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        hold_q <= hold_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem_q[wp_q] <= push_data;
    end

`ifdef MULTI_DATAFLOW_STREAMER_GEN_PERF_EN
    logic [15:0] stall_q, stall_d;
    always_comb begin
      stall_d = stall_q;
      if (clear_i | start_acc) stall_d = '0;
      else if (run & req & ~tcdm_gnt_i[i] & (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
    end
    assign stall_cnt_o[i*16 +: 16] = stall_q;
`else
    assign stall_cnt_o[i*16 +: 16] = '0;
`endif
  end
endmodule
